// File: rtl/led_vu_meter.sv
// Stereo VU-meter LED bar: |sample| peak detect, instant attack, timed exponential decay.
// Optional peak-hold dot is compiled in when VU_PEAK_HOLD_EN is defined.
module led_vu_meter #(
  parameter int DECAY_CYCLES = 500000,
  parameter int HOLD_CYCLES  = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  // valid is a one-cycle strobe with no back-pressure: lft_out/rht_out are
  // consumed on every cycle valid is high, and every such sample is evaluated.
  input  logic        valid,
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out,
  output logic [7:0]  LED
);

  localparam int CNT_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_CYCLES - 1);

  logic [14:0]      mag;
  logic             mag_vld;
  logic [14:0]      lvl;
  logic [CNT_W-1:0] decay_cnt;
  logic             tick;
  logic [14:0]      lvl_step;
  logic [3:0]       bar_n;
  logic [7:0]       bar;
  logic [14:0]      abs_l;
  logic [14:0]      abs_r;

  // Magnitude of a signed sample; the most negative code saturates to full scale.
  function automatic logic [14:0] abs15(input logic [15:0] x);
    logic [15:0] neg;
    neg = -x;
    if (!x[15])
      return x[14:0];
    else if (x == 16'h8000)
      return 15'h7FFF;
    else
      return neg[14:0];
  endfunction

  always_comb begin
    abs_l = abs15(lft_out);
    abs_r = abs15(rht_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag     <= '0;
      mag_vld <= 1'b0;
    end else begin
      mag_vld <= valid;
      if (valid)
        mag <= (abs_l >= abs_r) ? abs_l : abs_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      decay_cnt <= '0;
    else if (decay_cnt == CNT_LAST)
      decay_cnt <= '0;
    else
      decay_cnt <= decay_cnt + 1'b1;
  end

  assign tick = (decay_cnt == CNT_LAST);

  // Step of at least 1 so small levels still drain to zero.
  always_comb begin
    lvl_step = (lvl[14:4] == 11'd0) ? 15'd1 : {4'd0, lvl[14:4]};
  end

  always_ff @(posedge clk) begin
    if (rst)
      lvl <= '0;
    else if (mag_vld && (mag >= lvl))
      lvl <= mag;
    else if (tick && (lvl != 15'd0))
      lvl <= lvl - lvl_step;
  end

  always_comb begin
    bar_n = (lvl < 15'd256) ? 4'd0 : ({1'b0, lvl[14:12]} + 4'd1);
    bar   = '0;
    for (int i = 0; i < 8; i++)
      bar[i] = (4'(i) < bar_n);
  end

`ifdef VU_PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [3:0]        pk;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0]        dot;

  always_ff @(posedge clk) begin
    if (rst) begin
      pk       <= '0;
      hold_cnt <= '0;
    end else if (bar_n > pk) begin
      pk       <= bar_n;
      hold_cnt <= HOLD_W'(HOLD_CYCLES);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end else if (tick && (pk > bar_n)) begin
      pk <= pk - 4'd1;
    end
  end

  always_comb begin
    dot = '0;
    for (int i = 0; i < 8; i++)
      dot[i] = (pk == 4'(i + 1));
  end

  always_ff @(posedge clk) begin
    if (rst)
      LED <= '0;
    else
      LED <= bar | dot;
  end
`else
  always_ff @(posedge clk) begin
    if (rst)
      LED <= '0;
    else
      LED <= bar;
  end
`endif

endmodule

// File: tb/tb_led_vu_meter.sv
// Directed bench for led_vu_meter with short decay/hold periods; each task checks
// its own expected LED / level values computed by hand.
module tb_led_vu_meter;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [15:0] lft_out;
  logic [15:0] rht_out;
  logic [7:0]  LED;

  int checks;
  int errors;

  led_vu_meter #(.DECAY_CYCLES(4), .HOLD_CYCLES(20)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .LED     (LED)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n clock edges, leaving time 1 unit after the last edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] l, input logic [15:0] r);
    valid   = v;
    lft_out = l;
    rht_out = r;
  endtask

  // after return we sit just past the last reset edge (edge 0 of a scenario)
  task automatic do_reset();
    drive(1'b0, 16'h0, 16'h0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      step(1);
    end
    checks++;
    if (LED !== 8'h00) begin
      errors++;
      $display("FAIL reset_led: got %h expected 00", LED);
    end
    drive(1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++;
      if (LED !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h expected 00", i, LED);
      end
    end
  endtask

  task automatic test_attack_latency();
    logic [7:0] exp_led [1:3];
    exp_led[1] = 8'h00; exp_led[2] = 8'h00; exp_led[3] = 8'h1F;
    do_reset();
    drive(1'b1, 16'h4000, 16'h0000);
    for (int c = 1; c <= 3; c++) begin
      step(1);
      drive(1'b0, 16'h0, 16'h0);
      checks++;
      if (LED !== exp_led[c]) begin
        errors++;
        $display("FAIL attack_cycle%0d: got %h expected %h", c, LED, exp_led[c]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 16'h0100, 16'h8000);
    step(1);
    drive(1'b0, 16'h0, 16'h0);
    step(2);
    checks++;
    if (LED !== 8'hFF) begin
      errors++;
      $display("FAIL sat_max: got %h expected FF", LED);
    end
    do_reset();
    drive(1'b1, 16'h0000, 16'hFF00);
    step(1);
    drive(1'b0, 16'h0, 16'h0);
    step(2);
    checks++;
    if (LED !== 8'h01) begin
      errors++;
      $display("FAIL neg256: got %h expected 01", LED);
    end
  endtask

  // ticks take effect on edges 4, 8, 12, 16, 20 after the reset edge
  task automatic test_decay();
    do_reset();
    drive(1'b1, 16'd300, 16'd0);
    step(1);                            // edge 1
    drive(1'b0, 16'h0, 16'h0);
    step(1);                            // edge 2
    checks++;
    if (dut.lvl !== 15'd300) begin errors++; $display("FAIL decay_load: lvl %0d expected 300", dut.lvl); end
    step(1);                            // edge 3
    checks++;
    if (LED !== 8'h01) begin errors++; $display("FAIL decay_led300: got %h expected 01", LED); end
    step(1);                            // edge 4
    checks++;
    if (dut.lvl !== 15'd282) begin errors++; $display("FAIL decay_tick1: lvl %0d expected 282", dut.lvl); end
    step(4);                            // edge 8
    checks++;
    if (dut.lvl !== 15'd265) begin errors++; $display("FAIL decay_tick2: lvl %0d expected 265", dut.lvl); end
    step(1);                            // edge 9
    checks++;
    if (LED !== 8'h01) begin errors++; $display("FAIL decay_led265: got %h expected 01", LED); end
    step(3);                            // edge 12
    checks++;
    if (dut.lvl !== 15'd249) begin errors++; $display("FAIL decay_tick3: lvl %0d expected 249", dut.lvl); end
    step(1);                            // edge 13
    checks++;
    if (LED !== 8'h00) begin errors++; $display("FAIL decay_led249: got %h expected 00", LED); end
    step(1);                            // edge 14
    drive(1'b1, 16'd1000, 16'd0);       // captured at edge 15, mag_vld during tick cycle
    step(1);                            // edge 15
    drive(1'b0, 16'h0, 16'h0);
    step(1);                            // edge 16 (tick)
    checks++;
    if (dut.lvl !== 15'd1000) begin errors++; $display("FAIL attack_on_tick: lvl %0d expected 1000", dut.lvl); end
    step(1);                            // edge 17
    checks++;
    if (LED !== 8'h01) begin errors++; $display("FAIL led1000: got %h expected 01", LED); end
    step(3);                            // edge 20 (tick)
    checks++;
    if (dut.lvl !== 15'd938) begin errors++; $display("FAIL decay_1000: lvl %0d expected 938", dut.lvl); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] smp [4];
    logic [7:0]  exp_led [4];
    smp[0] = 16'd256;   exp_led[0] = 8'h01;
    smp[1] = 16'hF000;  exp_led[1] = 8'h03;  // -4096
    smp[2] = 16'd8192;  exp_led[2] = 8'h07;
    smp[3] = 16'hD000;  exp_led[3] = 8'h0F;  // -12288
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i % 2 == 0) ? smp[i] : 16'd5, (i % 2 == 0) ? 16'd3 : smp[i]);
      step(1);
    end
    drive(1'b0, 16'h0, 16'h0);
    step(1);                            // edge 5 -> sample 0 on LED after edge 3
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1);
      // edge 3+i shows sample i; we are at edge 3+i only for i>=2, so index by timing below
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i % 2 == 0) ? smp[i] : 16'd5, (i % 2 == 0) ? 16'd3 : smp[i]);
      step(1);                          // edge i+1
      if (i >= 2) begin
        checks++;
        if (LED !== exp_led[i - 2]) begin
          errors++;
          $display("FAIL b2b_sample%0d: got %h expected %h", i - 2, LED, exp_led[i - 2]);
        end
      end
    end
    drive(1'b0, 16'h0, 16'h0);
    for (int i = 2; i < 4; i++) begin
      step(1);
      checks++;
      if (LED !== exp_led[i]) begin
        errors++;
        $display("FAIL b2b_sample%0d: got %h expected %h", i, LED, exp_led[i]);
      end
    end
  endtask

  task automatic test_reset_mid_operation();
    do_reset();
    drive(1'b1, 16'h7FFF, 16'h0000);
    step(3);                            // edge 3: LED full, another sample in stage 1
    drive(1'b0, 16'h0, 16'h0);
    checks++;
    if (LED !== 8'hFF || dut.mag_vld !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: LED %h mag_vld %b expected FF 1", LED, dut.mag_vld);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (LED !== 8'h00) begin errors++; $display("FAIL midrst_led: got %h expected 00", LED); end
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (LED !== 8'h00 || dut.lvl !== 15'd0) begin
        errors++;
        $display("FAIL midrst_flush[%0d]: LED %h lvl %0d expected 00 0", i, LED, dut.lvl);
      end
    end
  endtask

`ifdef VU_PEAK_HOLD_EN
  task automatic test_peak_hold();
    do_reset();
    drive(1'b1, 16'h7FFF, 16'h0000);
    step(1);                            // edge 1
    drive(1'b0, 16'h0, 16'h0);
    step(20);                           // edge 21: lvl 23731 (n=6), dot still held at 8
    checks++;
    if (LED !== 8'hBF) begin errors++; $display("FAIL peak_held: got %h expected BF", LED); end
    step(4);                            // edge 25: dot fell to 7
    checks++;
    if (LED !== 8'h7F) begin errors++; $display("FAIL peak_fall1: got %h expected 7F", LED); end
    step(4);                            // edge 29: dot merged with bar at 6
    checks++;
    if (LED !== 8'h3F) begin errors++; $display("FAIL peak_merge: got %h expected 3F", LED); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0);
    test_reset();
    test_attack_latency();
    test_saturation();
    test_decay();
    test_back_to_back();
    test_reset_mid_operation();
`ifdef VU_PEAK_HOLD_EN
    test_peak_hold();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
